// File: rtl/subleq_core.sv
// subleq_core: SUBLEQ execution engine and sole master of a 2R/1W 64x32
// data memory. Each instruction is FETCH -> DECODE -> EXEC (3 cycles),
// plus stall cycles in EXEC while waiting for an input byte.
//
// Instruction word: A=[5:0], B=[13:8], C=[21:16]; all other bits ignored.
// mem[A] <= mem[A] - mem[B]; if the result is <= 0, pc <= C, else pc <= pc+1.
// A taken branch to 63 halts.
//
// Optional feature macro: SUBLEQ_IO_EN (operand address 62 maps to I/O).
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   run                        start/resume level
//   busy, halted, pc           registered status
//   mem_w_ena/addr/data        memory write port (EXEC commit cycle only)
//   mem_ra_addr/mem_ra_data    read port A (data valid one cycle after addr)
//   mem_rb_addr/mem_rb_data    read port B (data valid one cycle after addr)
//   in_data, in_valid, in_ready   input byte handshake (I/O builds)
//   out_data, out_valid        registered output byte and one-cycle strobe
module subleq_core #(
  parameter logic [5:0] RESET_PC = 6'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        busy,
  output logic        halted,
  output logic [5:0]  pc,
  output logic        mem_w_ena,
  output logic [5:0]  mem_w_addr,
  output logic [31:0] mem_w_data,
  output logic [5:0]  mem_ra_addr,
  input  logic [31:0] mem_ra_data,
  output logic [5:0]  mem_rb_addr,
  input  logic [31:0] mem_rb_data,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid
);

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 32;
  localparam int unsigned A_LSB = 0;
  localparam int unsigned B_LSB = 8;
  localparam int unsigned C_LSB = 16;
  localparam logic [AW-1:0] HALT_ADDR = 6'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_next;
  logic [AW-1:0] r_a;
  logic [AW-1:0] r_b;
  logic [AW-1:0] r_c;
  logic          r_busy;
  logic          r_halted;
  logic [DW-1:0] w_opa;
  logic [DW-1:0] w_opb;
  logic [DW-1:0] w_diff;
  logic          w_taken;
  logic          w_a_io;
  logic          w_b_io;
  logic          w_stall;
  logic          w_commit;

  // Operand selection: memory, or the I/O port at address 62
`ifdef SUBLEQ_IO_EN
  localparam int unsigned BW = 8;
  localparam logic [AW-1:0] IO_ADDR = 6'h3E;

  assign w_a_io  = (r_a == IO_ADDR);
  assign w_b_io  = (r_b == IO_ADDR);
  assign w_stall = w_b_io && !in_valid;
  assign w_opa   = w_a_io ? '0 : mem_ra_data;
  assign w_opb   = w_b_io ? {{(DW-BW){in_data[BW-1]}}, in_data} : mem_rb_data;
`else
  logic w_unused_io;

  assign w_a_io      = 1'b0;
  assign w_b_io      = 1'b0;
  assign w_stall     = 1'b0;
  assign w_opa       = mem_ra_data;
  assign w_opb       = mem_rb_data;
  assign w_unused_io = ^{in_data, in_valid};
`endif

  // Wrapping subtract; "<= 0" means sign bit set or all zero
  assign w_diff  = w_opa - w_opb;
  assign w_taken = w_diff[DW-1] || (w_diff == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state, pc update and memory port drive
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_commit     = 1'b0;
    mem_ra_addr  = '0;
    mem_rb_addr  = '0;
    mem_w_ena    = 1'b0;
    mem_w_addr   = '0;
    mem_w_data   = '0;
    in_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_ra_addr  = r_pc;
        w_state_next = S_DECODE;
      end
      S_DECODE: begin
        // Operand addresses come straight from the instruction word now on the bus
        mem_ra_addr  = mem_ra_data[A_LSB +: AW];
        mem_rb_addr  = mem_ra_data[B_LSB +: AW];
        w_state_next = S_EXEC;
      end
      S_EXEC: begin
        mem_ra_addr = r_a;
        mem_rb_addr = r_b;
        mem_w_addr  = r_a;
        mem_w_data  = w_diff;
        if (!w_stall) begin
          w_commit  = 1'b1;
          mem_w_ena = !w_a_io;
          in_ready  = w_b_io;
          if (w_taken) begin
            w_pc_next = r_c;
            if (r_c == HALT_ADDR) w_state_next = S_HALT;
            else if (run)         w_state_next = S_FETCH;
            else                  w_state_next = S_IDLE;
          end else begin
            w_pc_next    = r_pc + AW'(1);
            w_state_next = run ? S_FETCH : S_IDLE;
          end
        end
      end
      S_HALT: begin
        if (run) begin
          w_pc_next    = RESET_PC;
          w_state_next = S_FETCH;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // pc, decoded fields and registered status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (r_state == S_DECODE) begin
        r_a <= mem_ra_data[A_LSB +: AW];
        r_b <= mem_ra_data[B_LSB +: AW];
        r_c <= mem_ra_data[C_LSB +: AW];
      end
      r_busy   <= (w_state_next == S_FETCH) || (w_state_next == S_DECODE) ||
                  (w_state_next == S_EXEC);
      r_halted <= (w_state_next == S_HALT);
    end
  end

  // Output byte register, pulsed for one cycle after a commit with A == 62
`ifdef SUBLEQ_IO_EN
  logic          r_out_valid;
  logic [BW-1:0] r_out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_commit && w_a_io;
      if (w_commit && w_a_io) r_out_data <= w_diff[BW-1:0];
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
`else
  logic w_unused_commit;

  assign out_valid       = 1'b0;
  assign out_data        = '0;
  assign w_unused_commit = w_commit;
`endif

  assign busy   = r_busy;
  assign halted = r_halted;
  assign pc     = r_pc;

endmodule

// File: tb/tb_subleq_core.sv
// Bench for subleq_core: two instances (RESET_PC = 0 and 63) each with a
// behavioural 64x32 memory (1-cycle registered reads). Writes and output
// bytes are checked against scoreboard queues at the falling edge.
module tb_subleq_core;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] exp_val;
    logic [5:0]  exp_pc;
    logic        exp_halt;
  } vec_t;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        run0, run1;
  logic        busy0, busy1, halted0, halted1;
  logic [5:0]  pc0, pc1;
  logic        w_ena0, w_ena1;
  logic [5:0]  w_addr0, w_addr1;
  logic [31:0] w_data0, w_data1;
  logic [5:0]  ra_addr0, ra_addr1, rb_addr0, rb_addr1;
  logic [31:0] ra_data0, ra_data1, rb_data0, rb_data1;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready0, in_ready1;
  logic [7:0]  out_data0, out_data1;
  logic        out_valid0, out_valid1;

  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];
  logic        ld_en0, ld_en1;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;

  int   checks = 0;
  int   errors = 0;
  int   n_wr0  = 0;
  int   n_out  = 0;
  wr_t  exp_wq [$];
  logic [7:0] exp_oq [$];
  wr_t  mon_w;
  logic [7:0] mon_o;
  vec_t vecs [7];
  int   nw, no;

  subleq_core #(.RESET_PC(6'd0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .run(run0), .busy(busy0), .halted(halted0), .pc(pc0),
    .mem_w_ena(w_ena0), .mem_w_addr(w_addr0), .mem_w_data(w_data0),
    .mem_ra_addr(ra_addr0), .mem_ra_data(ra_data0),
    .mem_rb_addr(rb_addr0), .mem_rb_data(rb_data0),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .out_data(out_data0), .out_valid(out_valid0)
  );

  subleq_core #(.RESET_PC(6'd63)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .run(run1), .busy(busy1), .halted(halted1), .pc(pc1),
    .mem_w_ena(w_ena1), .mem_w_addr(w_addr1), .mem_w_data(w_data1),
    .mem_ra_addr(ra_addr1), .mem_ra_data(ra_data1),
    .mem_rb_addr(rb_addr1), .mem_rb_data(rb_data1),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1)
  );

  // Memories: load port has priority over the core write port
  always @(posedge clk) begin
    if (ld_en0)      mem0[ld_addr] <= ld_data;
    else if (w_ena0) mem0[w_addr0] <= w_data0;
    ra_data0 <= mem0[ra_addr0];
    rb_data0 <= mem0[rb_addr0];
  end

  always @(posedge clk) begin
    if (ld_en1)      mem1[ld_addr] <= ld_data;
    else if (w_ena1) mem1[w_addr1] <= w_data1;
    ra_data1 <= mem1[ra_addr1];
    rb_data1 <= mem1[rb_addr1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Write scoreboard for instance 0
  always @(negedge clk) begin
    if (rst_n && w_ena0) begin
      n_wr0 <= n_wr0 + 1;
      if (exp_wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%0d data=0x%08h required=none", w_addr0, w_data0);
      end else begin
        mon_w = exp_wq.pop_front();
        chk("wr_addr", 32'(w_addr0), 32'(mon_w.addr));
        chk("wr_data", w_data0, mon_w.data);
      end
    end
  end

  // Output byte scoreboard for instance 0
  always @(negedge clk) begin
    if (rst_n && out_valid0) begin
      n_out <= n_out + 1;
      if (exp_oq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out data=0x%02h required=none", out_data0);
      end else begin
        mon_o = exp_oq.pop_front();
        chk("out_data", 32'(out_data0), 32'(mon_o));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic load(input int sel, input logic [5:0] a, input logic [31:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en0  = (sel == 0);
    ld_en1  = (sel == 1);
    step(1);
    ld_en0  = 1'b0;
    ld_en1  = 1'b0;
  endtask

  task automatic expect_wr(input logic [5:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_wq.push_back(e);
  endtask

  // One-cycle run pulse on instance 0; returns in FETCH
  task automatic pulse0();
    run0 = 1'b1;
    step(1);
    run0 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; run0 = 1'b0; run1 = 1'b0;
    in_data = 8'h00; in_valid = 1'b0;
    ld_en0 = 1'b0; ld_en1 = 1'b0; ld_addr = '0; ld_data = '0;

    //          instr         A value       B value       result        pc     halt
    vecs[0] = '{32'h00050B0A, 32'd7,        32'd3,        32'd4,        6'd1,  1'b0};
    vecs[1] = '{32'hFFC5CBCA, 32'd9,        32'd4,        32'd5,        6'd1,  1'b0};
    vecs[2] = '{32'h00050B0A, 32'd3,        32'd3,        32'd0,        6'd5,  1'b0};
    vecs[3] = '{32'h00050B0A, 32'h80000000, 32'd1,        32'h7FFFFFFF, 6'd1,  1'b0};
    vecs[4] = '{32'h00050B0A, 32'd0,        32'd1,        32'hFFFFFFFF, 6'd5,  1'b0};
    vecs[5] = '{32'h00050B0A, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 6'd5,  1'b0};
    vecs[6] = '{32'h003F0A0A, 32'h12345678, 32'd0,        32'd0,        6'd63, 1'b1};

    step(2);
    rst_n = 1'b1;
    step(1);
    chk("rst_busy",     32'(busy0),     32'd0);
    chk("rst_halted",   32'(halted0),   32'd0);
    chk("rst_pc",       32'(pc0),       32'd0);
    chk("rst_pc_r63",   32'(pc1),       32'd63);
    chk("rst_w_ena",    32'(w_ena0),    32'd0);
    chk("rst_ra_addr",  32'(ra_addr0),  32'd0);
    chk("rst_rb_addr",  32'(rb_addr0),  32'd0);
    chk("rst_w_addr",   32'(w_addr0),   32'd0);
    chk("rst_in_ready", 32'(in_ready0), 32'd0);
    chk("rst_out",      32'({out_valid0, out_data0}), 32'd0);

    // Single instructions from address 0; the last one halts
    for (int i = 0; i < 7; i++) begin
      do_reset();
      load(0, 6'd0,  vecs[i].instr);
      load(0, 6'd10, vecs[i].av);
      load(0, 6'd11, vecs[i].bv);
      expect_wr(6'd10, vecs[i].exp_val);
      nw = n_wr0;
      pulse0();
      step(3);
      chk($sformatf("v%0d_pc", i),     32'(pc0),     32'(vecs[i].exp_pc));
      chk($sformatf("v%0d_mem", i),    mem0[10],     vecs[i].exp_val);
      chk($sformatf("v%0d_busy", i),   32'(busy0),   32'd0);
      chk($sformatf("v%0d_halted", i), 32'(halted0), 32'(vecs[i].exp_halt));
      chk($sformatf("v%0d_nwrites", i), 32'(n_wr0 - nw), 32'd1);
    end

    // Restart from HALT fetches at RESET_PC
    load(0, 6'd0,  32'h00050B0A);
    load(0, 6'd10, 32'd9);
    load(0, 6'd11, 32'd2);
    expect_wr(6'd10, 32'd7);
    nw = n_wr0;
    pulse0();
    chk("restart_halted", 32'(halted0),  32'd0);
    chk("restart_busy",   32'(busy0),    32'd1);
    chk("restart_pc",     32'(pc0),      32'd0);
    chk("fetch_addr",     32'(ra_addr0), 32'd0);
    step(1);
    chk("decode_ra",      32'(ra_addr0), 32'd10);
    chk("decode_rb",      32'(rb_addr0), 32'd11);
    step(2);
    chk("restart_pc_end", 32'(pc0),      32'd1);
    chk("restart_mem",    mem0[10],      32'd7);
    chk("restart_nwr",    32'(n_wr0 - nw), 32'd1);

    // RESET_PC = 63: wrap to 0, run dropped in DECODE, resume at pc
    do_reset();
    chk("r63_pc_reset", 32'(pc1), 32'd63);
    load(1, 6'd63, 32'h00050B0A);
    load(1, 6'd10, 32'd7);
    load(1, 6'd11, 32'd3);
    run1 = 1'b1;
    step(2);
    chk("r63_decode_busy", 32'(busy1), 32'd1);
    chk("r63_decode_pc",   32'(pc1),   32'd63);
    run1 = 1'b0;
    step(2);
    chk("r63_wrap_pc",  32'(pc1),   32'd0);
    chk("r63_idle",     32'(busy1), 32'd0);
    chk("r63_mem",      mem1[10],   32'd4);
    step(2);
    chk("r63_stays_idle", 32'(busy1), 32'd0);
    load(1, 6'd0,  32'h00071514);
    load(1, 6'd20, 32'd1);
    load(1, 6'd21, 32'd5);
    run1 = 1'b1;
    step(1);
    run1 = 1'b0;
    step(3);
    chk("resume_pc",  32'(pc1), 32'd7);
    chk("resume_mem", mem1[20], 32'hFFFFFFFC);

`ifdef SUBLEQ_IO_EN
    // I/O: A == B == 62, input stalls 4 cycles then 0x05 arrives
    do_reset();
    load(0, 6'd0,  32'h00143E3E);
    load(0, 6'd62, 32'h00001234);
    in_valid = 1'b0;
    nw = n_wr0;
    no = n_out;
    pulse0();
    step(2);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall%0d_in_ready", k), 32'(in_ready0), 32'd0);
      chk($sformatf("stall%0d_w_ena", k),    32'(w_ena0),    32'd0);
      chk($sformatf("stall%0d_busy", k),     32'(busy0),     32'd1);
      step(1);
    end
    in_valid = 1'b1;
    in_data  = 8'h05;
    exp_oq.push_back(8'hFB);
    #1;
    chk("io_in_ready", 32'(in_ready0), 32'd1);
    chk("io_no_wena",  32'(w_ena0),    32'd0);
    step(1);
    in_valid = 1'b0;
    chk("io_pc",        32'(pc0),        32'd20);
    chk("io_out_valid", 32'(out_valid0), 32'd1);
    step(1);
    chk("io_out_pulse_end", 32'(out_valid0), 32'd0);
    chk("io_nout",      32'(n_out - no), 32'd1);
    chk("io_nwr",       32'(n_wr0 - nw), 32'd0);
    chk("io_mem62",     mem0[62],        32'h00001234);
`else
    // Without I/O, address 62 is plain memory and the input port is ignored
    do_reset();
    load(0, 6'd0,  32'h00143E3E);
    load(0, 6'd62, 32'd9);
    in_valid = 1'b1;
    in_data  = 8'h05;
    expect_wr(6'd62, 32'd0);
    nw = n_wr0;
    pulse0();
    step(2);
    chk("noio_in_ready", 32'(in_ready0), 32'd0);
    step(1);
    in_valid = 1'b0;
    chk("noio_pc",        32'(pc0),        32'd20);
    chk("noio_mem62",     mem0[62],        32'd0);
    chk("noio_out_valid", 32'(out_valid0), 32'd0);
    chk("noio_nwr",       32'(n_wr0 - nw), 32'd1);
`endif

    // Async reset in EXEC: write suppressed, back to IDLE at RESET_PC
    do_reset();
    load(0, 6'd0,  32'h00050B0A);
    load(0, 6'd10, 32'd7);
    load(0, 6'd11, 32'd3);
    nw = n_wr0;
    pulse0();
    step(2);
    chk("exec_w_ena", 32'(w_ena0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_w_ena", 32'(w_ena0), 32'd0);
    chk("arst_pc",    32'(pc0),    32'd0);
    chk("arst_busy",  32'(busy0),  32'd0);
    step(1);
    rst_n = 1'b1;
    step(3);
    chk("arst_mem",   mem0[10],    32'd7);
    chk("arst_idle",  32'(busy0),  32'd0);
    chk("arst_pc2",   32'(pc0),    32'd0);
    chk("arst_nwr",   32'(n_wr0 - nw), 32'd0);

    step(1);
    chk("wr_queue_left",  32'(exp_wq.size()), 32'd0);
    chk("out_queue_left", 32'(exp_oq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
